multicycle_ctrl: RTL

//  Multi-cycle RV32I control FSM. Sits upstream of the ALU in the core.

---
 rtl/ctrl_pkg.sv | 93 +++++++++
 rtl/alu_funct_dec.sv | 54 +++++
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multicycle RV32I control path.
//   - FSM state encodings (4-bit, also exported on dbg_state)
//   - RV32I major opcodes
//   - ALU funct codes: {jalr_mask[9], alt[8], 5'b0, funct3[2:0]}
//   - operand / immediate / writeback / PC / address select codes
//   - ctrl_t: the bundle of control outputs decoded per state
//   - branch_taken(): map funct3 + ALU zero flag to a branch decision
package ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_ALU_WB   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [9:0] F_ADD  = 10'h000;
    localparam logic [9:0] F_SUB  = 10'h100;
    localparam logic [9:0] F_SLL  = 10'h001;
    localparam logic [9:0] F_SLT  = 10'h002;
    localparam logic [9:0] F_SLTU = 10'h003;
    localparam logic [9:0] F_XOR  = 10'h004;
    localparam logic [9:0] F_SRL  = 10'h005;
    localparam logic [9:0] F_SRA  = 10'h105;
    localparam logic [9:0] F_OR   = 10'h006;
    localparam logic [9:0] F_AND  = 10'h007;
    localparam logic [9:0] F_ADDJ = 10'h200;

    localparam logic [1:0] SRC_A_RS1    = 2'd0;
    localparam logic [1:0] SRC_A_PC     = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    typedef struct packed {
        logic [9:0] alu_funct;
        logic [1:0] src_a_sel;
        logic [1:0] src_b_sel;
        logic [2:0] imm_sel;
        logic       pc_src_sel;
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_we;
        logic       adr_sel;
        logic       illegal;
    } ctrl_t;

    // BEQ/BGE/BGEU branch when the compare result is zero, BNE/BLT/BLTU when
    // it is non-zero; funct3[0]^funct3[2] selects the inverted sense.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return zero ^ funct3[0] ^ funct3[2];
    endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// alu_funct_dec: combinational ALU function decoder.
//   opcode  in  7   instruction opcode
//   funct3  in  3   instruction funct3
//   funct7  in  7   instruction funct7 (imm[11:5] for OP-IMM)
//   funct   out 10  ALU funct code {jalr_mask, alt, 5'b0, funct3}
//   legal   out 1   encoding is supported for this opcode
module alu_funct_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [9:0] funct,
    output logic       legal
);

    always_comb begin
        funct = F_ADD;
        legal = 1'b1;
        case (opcode)
            OP_R: begin
                funct = {1'b0, funct7[5], 5'b0, funct3};
                if (funct7 != 7'h00 && funct7 != 7'h20)
                    legal = 1'b0;
                else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
                    legal = 1'b0;
            end
            OP_IMM: begin
                // Only shifts carry a funct7; for the rest those bits are
                // immediate, so the alt bit is forced off and never checked.
                if (funct3 == 3'b101) begin
                    funct = {1'b0, funct7[5], 5'b0, funct3};
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                end else begin
                    funct = {2'b00, 5'b0, funct3};
                    if (funct3 == 3'b001)
                        legal = (funct7 == 7'h00);
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: funct = F_SUB;
                    3'b100, 3'b101: funct = F_SLT;
                    3'b110, 3'b111: funct = F_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            OP_JALR: funct = F_ADDJ;
            OP_LOAD, OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: funct = F_ADD;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM driving the datapath
// (ALU funct, operand selects, PC/IR/regfile/memory strobes).
//   clk, resetn          core clock / async active-low reset
//   instr[31:0]          IR contents (valid from DECODE onward)
//   mem_ready            memory accepts/completes the current request
//   alu_zero             ALU zero flag (branch decision only)
//   alu_funct            ALU op code
//   src_a_sel/src_b_sel  ALU operand selects
//   imm_sel              immediate format select
//   pc_src_sel, pc_we    PC source / write
//   ir_we                IR + OLD_PC write
//   reg_we, wb_sel       regfile write / writeback source
//   mem_req, mem_we, adr_sel  memory request / write / address source
//   illegal              unsupported encoding seen
//   dbg_state            current FSM state when DBG_STATE=1, else 0
// Build option: CTRL_ILLEGAL_TRAP_EN makes ILLEGAL a sticky trap state left
// only through reset; otherwise ILLEGAL is a one-cycle NOP back to FETCH.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int FUNCT_W   = 10,
    parameter int DBG_STATE = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               alu_zero,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic [1:0]         src_a_sel,
    output logic [1:0]         src_b_sel,
    output logic [2:0]         imm_sel,
    output logic               pc_src_sel,
    output logic               pc_we,
    output logic               ir_we,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adr_sel,
    output logic               illegal,
    output logic [3:0]         dbg_state
);

    logic [3:0] state, state_nxt;
    ctrl_t      ctl;
    logic [9:0] dec_funct;
    logic       dec_legal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register / immediate fields belong to the datapath.
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    alu_funct_dec u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .funct  (dec_funct),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_FETCH;
        else         state <= state_nxt;
    end

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                // ALU forms PC+4 while the instruction is fetched; PC and IR
                // latch together on the completing cycle.
                ctl.mem_req   = 1'b1;
                ctl.adr_sel   = ADR_PC;
                ctl.src_a_sel = SRC_A_PC;
                ctl.src_b_sel = SRC_B_FOUR;
                ctl.alu_funct = F_ADD;
                if (mem_ready) begin
                    ctl.ir_we      = 1'b1;
                    ctl.pc_we      = 1'b1;
                    ctl.pc_src_sel = PC_SRC_ALU;
                    state_nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative OLD_PC+imm lands in ALUOut as the branch/JAL target.
                ctl.src_a_sel = SRC_A_OLD_PC;
                ctl.src_b_sel = SRC_B_IMM;
                ctl.imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                ctl.alu_funct = F_ADD;
                case (opcode)
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_IMM:            state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_LUI: begin
                        ctl.src_a_sel = SRC_A_ZERO;
                        ctl.imm_sel   = IMM_U;
                        state_nxt     = S_ALU_WB;
                    end
                    OP_AUIPC: begin
                        ctl.imm_sel = IMM_U;
                        state_nxt   = S_ALU_WB;
                    end
                    default:           state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                ctl.src_a_sel = SRC_A_RS1;
                ctl.src_b_sel = SRC_B_RS2;
                ctl.alu_funct = dec_funct;
                state_nxt     = dec_legal ? S_ALU_WB : S_ILLEGAL;
            end
            S_EXEC_I: begin
                ctl.src_a_sel = SRC_A_RS1;
                ctl.src_b_sel = SRC_B_IMM;
                ctl.imm_sel   = IMM_I;
                ctl.alu_funct = dec_funct;
                state_nxt     = dec_legal ? S_ALU_WB : S_ILLEGAL;
            end
            S_ALU_WB: begin
                ctl.reg_we = 1'b1;
                ctl.wb_sel = WB_ALUOUT;
                state_nxt  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.src_a_sel = SRC_A_RS1;
                ctl.src_b_sel = SRC_B_IMM;
                ctl.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                ctl.alu_funct = F_ADD;
                state_nxt     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_req = 1'b1;
                ctl.adr_sel = ADR_ALUOUT;
                if (mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WR: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                ctl.adr_sel = ADR_ALUOUT;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_MEM_WB: begin
                ctl.reg_we = 1'b1;
                ctl.wb_sel = WB_MDR;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                // Target already sits in ALUOut; the ALU only compares here.
                ctl.src_a_sel  = SRC_A_RS1;
                ctl.src_b_sel  = SRC_B_RS2;
                ctl.alu_funct  = dec_funct;
                ctl.pc_src_sel = PC_SRC_ALUOUT;
                if (dec_legal) begin
                    ctl.pc_we = branch_taken(funct3, alu_zero);
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_ILLEGAL;
                end
            end
            S_JAL: begin
                // Link value is the already-incremented PC.
                ctl.pc_we      = 1'b1;
                ctl.pc_src_sel = PC_SRC_ALUOUT;
                ctl.reg_we     = 1'b1;
                ctl.wb_sel     = WB_PC;
                state_nxt      = S_FETCH;
            end
            S_JALR: begin
                // ADDJ clears bit 0 of rs1+imm; the sum goes straight to PC.
                ctl.src_a_sel  = SRC_A_RS1;
                ctl.src_b_sel  = SRC_B_IMM;
                ctl.imm_sel    = IMM_I;
                ctl.alu_funct  = F_ADDJ;
                ctl.pc_we      = 1'b1;
                ctl.pc_src_sel = PC_SRC_ALU;
                ctl.reg_we     = 1'b1;
                ctl.wb_sel     = WB_PC;
                state_nxt      = S_FETCH;
            end
            S_ILLEGAL: begin
                ctl.illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_nxt = S_ILLEGAL;
`else
                state_nxt = S_FETCH;
`endif
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are forced low combinationally while reset is asserted so an
    // in-flight memory request drops immediately, not at the next edge.
    assign alu_funct  = resetn ? FUNCT_W'(ctl.alu_funct) : '0;
    assign src_a_sel  = resetn ? ctl.src_a_sel  : 2'd0;
    assign src_b_sel  = resetn ? ctl.src_b_sel  : 2'd0;
    assign imm_sel    = resetn ? ctl.imm_sel    : 3'd0;
    assign pc_src_sel = resetn & ctl.pc_src_sel;
    assign pc_we      = resetn & ctl.pc_we;
    assign ir_we      = resetn & ctl.ir_we;
    assign reg_we     = resetn & ctl.reg_we;
    assign wb_sel     = resetn ? ctl.wb_sel     : 2'd0;
    assign mem_req    = resetn & ctl.mem_req;
    assign mem_we     = resetn & ctl.mem_we;
    assign adr_sel    = resetn & ctl.adr_sel;
    assign illegal    = resetn & ctl.illegal;

    generate
        if (DBG_STATE != 0) begin : g_dbg
            assign dbg_state = state;
        end else begin : g_nodbg
            assign dbg_state = 4'd0;
        end
    endgenerate

endmodule
